ball_collision_sched: RTL
=========================

Name: ball_collision_sched

Overview:
Per-frame scheduler and arbiter for up to N_SPRITES ball sprite instances sharing one pixel stream.
- Arbitrates the sprites' per-pixel draw flags into one registered pixel select.
- Detects sprite-to-sprite overlap during active video.
- At vertical blank, issues one-cycle opposite pulses to the colliding sprites, then enforces a frame-count holdoff so the sprites can separate.
- Sits between the video timing counters / ball instances and the colour mux feeding the HDMI encoder.

Parameters:
N_SPRITES, 4, number of sprite draw inputs (2..8)
SEL_W, 2, width of o_pix_sel; must equal clog2(N_SPRITES)
X_RES, 640, active pixels per line
Y_RES, 480, active lines per frame
HOLDOFF_FRAMES, 8, frames after a collision during which no new collision is accepted (1..255)

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-high reset
i_hcnt  input  11  horizontal counter, 0 = first active pixel
i_vcnt  input  11  vertical counter, 0 = first active line
i_draw  input  N_SPRITES  per-sprite draw flags, aligned to i_hcnt/i_vcnt
i_enable  input  1  collision scheduling enable
o_opposite  output  N_SPRITES  one-cycle reverse-direction pulse per sprite
o_pix_valid  output  1  some sprite covers the current active pixel
o_pix_sel  output  SEL_W  index of the winning sprite
o_hit_count  output  16  collision frames seen, saturating
o_busy  output  1  high in RESOLVE or HOLDOFF

Behaviour:
- Reset: all outputs 0, state IDLE, overlap mask 0, holdoff counter 0.
- Definitions:
  - active = (i_hcnt < X_RES) && (i_vcnt < Y_RES)
  - frame_start = (i_vcnt == 0) && (i_hcnt == 0)
  - vblank_start = (i_vcnt == Y_RES) && (i_hcnt == 0)
- Arbitration runs in every state, including IDLE, with latency 1 clk:
  - o_pix_valid <= active && |i_draw
  - o_pix_sel <= lowest set index of i_draw; 0 when none is set
  - No fairness rotation; the lowest index is always the top layer.
- Overlap accumulation, SCAN state only: in each active cycle with two or more i_draw bits set, OR those bits into the overlap mask.
- FSM:
  - IDLE: i_enable=1 -> WAIT.
  - WAIT: clear the mask; frame_start -> SCAN.
  - SCAN: accumulate; vblank_start -> RESOLVE.
  - RESOLVE (exactly 1 clk):
    - o_opposite <= mask for that one cycle only; 0 in every other cycle.
    - If mask != 0: o_hit_count += 1, saturating at 16'hFFFF; load holdoff = HOLDOFF_FRAMES; -> HOLDOFF.
    - Else -> WAIT.
  - HOLDOFF: decrement on each frame_start; at 0 -> WAIT. The next scan begins at the following frame_start, so the first scanned frame is HOLDOFF_FRAMES+1 frames after the pulse.
- i_enable=0 in any state -> IDLE next clk:
  - mask is cleared, the holdoff count is discarded, and no pulse is issued (including when RESOLVE is pending).
  - o_hit_count is retained; only rst clears it.
- Pulse timing: the pulse lands during vblank, before the sprites' next frame_start position update, so each sprite reverses exactly once per collision.
- A single sprite never sets its own mask bit. With three or more overlapping sprites, every participant gets a pulse.
- Counters outside the active area never accumulate; i_draw there is ignored.
- rst asserted mid-frame: immediate return to reset values; the scheduler resynchronises at the next frame_start via IDLE -> WAIT.

Optional Feature:
BALL_SCHED_OVERLAP_PX_EN
- Defined:
  - Adds output o_overlap_px[21:0].
  - During SCAN, counts active cycles with two or more draws set.
  - Latched to the output in RESOLVE (also when the count is 0); the counter clears in WAIT.
  - Reset value 0.
- Undefined: the port, counter and latch are absent; all other behaviour is identical.

Test Plan:
- Bench setup for all scenarios: X_RES=16, Y_RES=8, hcnt wraps at 20, vcnt wraps at 10, N_SPRITES=4, HOLDOFF_FRAMES=2.
- Scenario 1, arbitration: i_draw=4'b1010 at hcnt=3,vcnt=2 -> next clk o_pix_valid=1, o_pix_sel=1. i_draw=4'b1010 at hcnt=17 -> o_pix_valid=0.
- Scenario 2, single collision: enable, then i_draw=4'b0011 for one active pixel in frame 1 -> at vblank_start+1 clk o_opposite=4'b0011 for exactly 1 clk, o_hit_count=1, o_busy=1.
- Scenario 3, holdoff: overlap persists in every frame -> pulses occur in frames 1 and 4 only; o_hit_count=2 after frame 4.
- Scenario 4, disable mid-SCAN: overlap in frame 1, i_enable=0 at vcnt=5 -> no o_opposite pulse, o_hit_count unchanged, state IDLE.
- Scenario 5, three-way overlap and saturation:
  - i_draw=4'b0111 -> o_opposite=4'b0111.
  - Force o_hit_count to 16'hFFFF, then collide -> stays 16'hFFFF.
  - With BALL_SCHED_OVERLAP_PX_EN defined, 5 overlap pixels -> o_overlap_px=5.

Source files
------------

// File: rtl/ball_collision_sched.sv
// Ball sprite scheduler: registered draw arbitration, overlap scan during active video,
// vblank collision pulses and a frame holdoff. Optional feature macro: BALL_SCHED_OVERLAP_PX_EN.
module ball_collision_sched #(
  parameter int N_SPRITES      = 4,
  parameter int SEL_W          = 2,
  parameter int X_RES          = 640,
  parameter int Y_RES          = 480,
  parameter int HOLDOFF_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [10:0]          i_hcnt,
  input  logic [10:0]          i_vcnt,
  input  logic [N_SPRITES-1:0] i_draw,
  input  logic                 i_enable,
  output logic [N_SPRITES-1:0] o_opposite,
  output logic                 o_pix_valid,
  output logic [SEL_W-1:0]     o_pix_sel,
  output logic [15:0]          o_hit_count,
  output logic                 o_busy
`ifdef BALL_SCHED_OVERLAP_PX_EN
  ,
  output logic [21:0]          o_overlap_px
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SCAN,
    S_RESOLVE,
    S_HOLDOFF
  } state_t;

  localparam logic [10:0]          X_LIM     = 11'(X_RES);
  localparam logic [10:0]          Y_LIM     = 11'(Y_RES);
  localparam logic [7:0]           HOLD_INIT = 8'(HOLDOFF_FRAMES);
  localparam logic [N_SPRITES-1:0] DRAW_ONE  = {{(N_SPRITES-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 next_state;
  logic [N_SPRITES-1:0]   mask;
  logic [7:0]             hold_cnt;
  logic [15:0]            hit_count;
  logic [SEL_W-1:0]       low_sel;

  logic active;
  logic frame_start;
  logic vblank_start;
  logic multi_draw;

  logic clr_mask;
  logic accumulate;
  logic resolve;
  logic hold_load;
  logic hold_dec;
  logic hold_clr;

  assign active       = (i_hcnt < X_LIM) && (i_vcnt < Y_LIM);
  assign frame_start  = (i_vcnt == 11'd0) && (i_hcnt == 11'd0);
  assign vblank_start = (i_vcnt == Y_LIM) && (i_hcnt == 11'd0);
  // Clearing the lowest set bit leaves something only when two or more sprites draw.
  assign multi_draw   = |(i_draw & (i_draw - DRAW_ONE));

  assign o_hit_count  = hit_count;
  assign o_busy       = (state == S_RESOLVE) || (state == S_HOLDOFF);

  // Lowest index wins: scan from the top so the final assignment is the lowest set bit.
  always_comb begin
    low_sel = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (i_draw[i]) low_sel = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    clr_mask   = 1'b0;
    accumulate = 1'b0;
    resolve    = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    hold_clr   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (i_enable) next_state = S_WAIT;
      end
      S_WAIT: begin
        clr_mask = 1'b1;
        if (frame_start) next_state = S_SCAN;
      end
      S_SCAN: begin
        accumulate = active && multi_draw;
        if (vblank_start) next_state = S_RESOLVE;
      end
      S_RESOLVE: begin
        resolve = 1'b1;
        if (|mask) begin
          hold_load  = 1'b1;
          next_state = S_HOLDOFF;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt == 8'd0)  next_state = S_WAIT;
        else if (frame_start)  hold_dec   = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase

    // Disable wins over everything, including a pending resolve.
    if (!i_enable) begin
      next_state = S_IDLE;
      clr_mask   = 1'b1;
      accumulate = 1'b0;
      resolve    = 1'b0;
      hold_load  = 1'b0;
      hold_dec   = 1'b0;
      hold_clr   = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pix_valid <= 1'b0;
      o_pix_sel   <= '0;
      o_opposite  <= '0;
      mask        <= '0;
      hold_cnt    <= 8'd0;
      hit_count   <= 16'd0;
    end else begin
      o_pix_valid <= active && (|i_draw);
      o_pix_sel   <= low_sel;
      o_opposite  <= resolve ? mask : '0;

      if (clr_mask)        mask <= '0;
      else if (accumulate) mask <= mask | i_draw;

      if (hold_clr)       hold_cnt <= 8'd0;
      else if (hold_load) hold_cnt <= HOLD_INIT;
      else if (hold_dec)  hold_cnt <= hold_cnt - 8'd1;

      if (resolve && (|mask) && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
    end
  end

`ifdef BALL_SCHED_OVERLAP_PX_EN
  logic [21:0] px_cnt;

  // A full 640x480 frame fits in 22 bits, so the counter cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_cnt       <= 22'd0;
      o_overlap_px <= 22'd0;
    end else begin
      if (clr_mask)        px_cnt <= 22'd0;
      else if (accumulate) px_cnt <= px_cnt + 22'd1;

      if (resolve) o_overlap_px <= px_cnt;
    end
  end
`endif

endmodule
